// File: rtl/pulse_scheduler.sv
// Trigger-to-pulse scheduler: one shared run counter drives NUM_CH delayed pulses,
// followed by a fixed holdoff; configuration is staged and copied in when arming.
module pulse_scheduler #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned CW      = 32,
   parameter int unsigned HOLDOFF = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_ch,
   input  logic              cfg_sel,
   input  logic [CW-1:0]     cfg_data,
   input  logic              arm,
   input  logic              cont,
   input  logic              abort,
   input  logic              trig,
   output logic [NUM_CH-1:0] y,
   output logic              armed,
   output logic              busy,
   output logic              done,
   output logic              missed
);

   localparam int unsigned HW = $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {IDLE, ARMED, RUNNING, HOLD} state_t;

   state_t            state;
   logic [CW-1:0]     stg_d [NUM_CH];
   logic [CW-1:0]     stg_w [NUM_CH];
   logic [CW-1:0]     act_d [NUM_CH];
   logic [CW-1:0]     act_w [NUM_CH];
   logic [CW:0]       ch_start [NUM_CH];
   logic [CW:0]       ch_end [NUM_CH];
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] y_nxt;
   logic [CW:0]       cnt;
   logic [CW:0]       cnt_nxt;
   logic [CW:0]       run_len;
   logic [HW-1:0]     hcnt;
   logic              cont_q;

   // Per-channel window bounds, one extra bit so D+W never wraps
   always_comb begin
      run_len = (CW+1)'(1);
      cnt_nxt = (&cnt) ? cnt : cnt + (CW+1)'(1);
      for (int i = 0; i < NUM_CH; i++) begin
         ch_en[i]    = (act_w[i] != '0);
         ch_start[i] = (act_d[i] == '0) ? (CW+1)'(1) : (CW+1)'(act_d[i]);
         ch_end[i]   = ch_start[i] + (CW+1)'(act_w[i]);
         y_nxt[i]    = ch_en[i] && (cnt_nxt >= ch_start[i]) && (cnt_nxt < ch_end[i]);
         if (ch_en[i] && (ch_end[i] > run_len)) run_len = ch_end[i];
      end
   end

   // Staging registers, writable at any time
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            stg_d[i] <= '0;
            stg_w[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_we && (cfg_ch == 3'(i))) begin
               if (cfg_sel) stg_w[i] <= cfg_data;
               else         stg_d[i] <= cfg_data;
            end
         end
      end
   end

   // Sequencer; active config only changes on entry to ARMED
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         hcnt   <= '0;
         cont_q <= 1'b0;
         y      <= '0;
         armed  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         missed <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            act_d[i] <= '0;
            act_w[i] <= '0;
         end
      end else begin
         done   <= 1'b0;
         missed <= 1'b0;
         if (abort) begin
            state <= IDLE;
            y     <= '0;
            armed <= 1'b0;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (arm) begin
                     state  <= ARMED;
                     armed  <= 1'b1;
                     cont_q <= cont;
                     for (int i = 0; i < NUM_CH; i++) begin
                        act_d[i] <= stg_d[i];
                        act_w[i] <= stg_w[i];
                     end
                  end
               end
               ARMED: begin
                  if (trig) begin
                     state <= RUNNING;
                     armed <= 1'b0;
                     busy  <= 1'b1;
                     cnt   <= '0;
                     y     <= '0;
                  end
               end
               RUNNING: begin
                  missed <= trig;
                  cnt    <= cnt_nxt;
                  if (cnt_nxt == run_len) begin
                     state <= HOLD;
                     done  <= 1'b1;
                     y     <= '0;
                     hcnt  <= '0;
                  end else begin
                     y <= y_nxt;
                  end
               end
               HOLD: begin
                  missed <= trig;
                  if (hcnt == HW'(HOLDOFF - 1)) begin
                     busy <= 1'b0;
                     if (cont_q) begin
                        state <= ARMED;
                        armed <= 1'b1;
                        for (int i = 0; i < NUM_CH; i++) begin
                           act_d[i] <= stg_d[i];
                           act_w[i] <= stg_w[i];
                        end
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     hcnt <= hcnt + HW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: runs, re-arm, mid-run config, missed, abort, edge widths.
module tb_pulse_scheduler;

   localparam int unsigned NUM_CH  = 4;
   localparam int unsigned CW      = 8;
   localparam int unsigned HOLDOFF = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic [2:0]        cfg_ch;
   logic              cfg_sel;
   logic [CW-1:0]     cfg_data;
   logic              arm;
   logic              cont;
   logic              abort;
   logic              trig;
   logic [NUM_CH-1:0] y;
   logic              armed;
   logic              busy;
   logic              done;
   logic              missed;

   int n_assert = 0;
   int n_fail   = 0;

   pulse_scheduler #(.NUM_CH(NUM_CH), .CW(CW), .HOLDOFF(HOLDOFF)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .arm(arm), .cont(cont), .abort(abort), .trig(trig),
      .y(y), .armed(armed), .busy(busy), .done(done), .missed(missed)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   task automatic cfg(input int ch, input bit sel, input int val);
      cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_sel = sel; cfg_data = CW'(val);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic arm_dut(input bit c);
      arm = 1'b1; cont = c;
      tick();
      arm = 1'b0; cont = 1'b0;
      chk("armed_after_arm", 0, 32'(armed), 32'd1);
   endtask

   // Trigger from ARMED and check every cycle through the end of holdoff.
   task automatic run(input int d0, input int w0, input int d1, input int w1, input bit end_armed,
                      input int wr_k, input int wr_val, input int tr_a, input int tr_b);
      int de0, de1, len, tot;
      logic [3:0] ey;
      de0 = (d0 < 1) ? 1 : d0;
      de1 = (d1 < 1) ? 1 : d1;
      len = 1;
      if (w0 != 0 && de0 + w0 > len) len = de0 + w0;
      if (w1 != 0 && de1 + w1 > len) len = de1 + w1;
      tot = len + int'(HOLDOFF);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      chk("busy_e0", 0, 32'(busy), 32'd1);
      chk("armed_e0", 0, 32'(armed), 32'd0);
      chk("y_e0", 0, 32'(y), 32'd0);
      for (int k = 1; k <= tot; k++) begin
         if (k == wr_k) begin
            cfg_we = 1'b1; cfg_ch = 3'd0; cfg_sel = 1'b0; cfg_data = CW'(wr_val);
         end
         trig = (k == tr_a || k == tr_b);
         tick();
         cfg_we = 1'b0;
         trig = 1'b0;
         ey = '0;
         ey[0] = (w0 != 0) && (k >= de0) && (k < de0 + w0);
         ey[1] = (w1 != 0) && (k >= de1) && (k < de1 + w1);
         chk("y", k, 32'(y), 32'(ey));
         chk("done", k, 32'(done), 32'(k == len));
         chk("busy", k, 32'(busy), 32'(k < tot));
         chk("armed", k, 32'(armed), 32'(k == tot && end_armed));
         chk("missed", k, 32'(missed), 32'(k == tr_a || k == tr_b));
      end
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
      arm = 1'b0; cont = 1'b0; abort = 1'b0; trig = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_y", 0, 32'(y), 32'd0);
      chk("rst_armed", 0, 32'(armed), 32'd0);
      chk("rst_busy", 0, 32'(busy), 32'd0);
      chk("rst_done", 0, 32'(done), 32'd0);
      chk("rst_missed", 0, 32'(missed), 32'd0);

      // single run, trigger in IDLE ignored
      cfg(0, 0, 5); cfg(0, 1, 3);
      trig = 1'b1; tick(); trig = 1'b0;
      chk("idle_trig_missed", 0, 32'(missed), 32'd0);
      chk("idle_trig_busy", 0, 32'(busy), 32'd0);
      arm_dut(1'b0);
      run(5, 3, 0, 0, 1'b0, -1, 0, -1, -1);

      // continuous mode, mid-run delay write, missed triggers
      cfg(0, 0, 2); cfg(0, 1, 4); cfg(1, 0, 10); cfg(1, 1, 1);
      arm_dut(1'b1);
      run(2, 4, 10, 1, 1'b1, -1, 0, -1, -1);
      run(2, 4, 10, 1, 1'b1, 3, 20, -1, -1);
      run(20, 4, 10, 1, 1'b1, -1, 0, 3, 29);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_armed", 0, 32'(armed), 32'd0);
      chk("abort_busy", 0, 32'(busy), 32'd0);

      // abort mid-pulse
      cfg(0, 0, 2); cfg(0, 1, 10); cfg(1, 1, 0);
      arm_dut(1'b0);
      trig = 1'b1; tick(); trig = 1'b0;
      tick(); chk("ab_y1", 1, 32'(y), 32'd0);
      tick(); chk("ab_y2", 2, 32'(y), 32'd1);
      tick(); chk("ab_y3", 3, 32'(y), 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("ab_y4", 4, 32'(y), 32'd0);
      chk("ab_busy", 4, 32'(busy), 32'd0);
      chk("ab_armed", 4, 32'(armed), 32'd0);
      chk("ab_done", 4, 32'(done), 32'd0);
      tick(); chk("ab_done5", 5, 32'(done), 32'd0);
      arm = 1'b1; trig = 1'b1; tick(); arm = 1'b0; trig = 1'b0;
      chk("armtrig_armed", 0, 32'(armed), 32'd1);
      chk("armtrig_busy", 0, 32'(busy), 32'd0);
      run(2, 10, 0, 0, 1'b0, -1, 0, -1, -1);

      // zero widths, out-of-range channel, zero delay, maximum delay
      cfg(4, 1, 7); cfg(0, 1, 0);
      arm_dut(1'b0);
      run(2, 0, 0, 0, 1'b0, -1, 0, -1, -1);
      cfg(0, 0, 0); cfg(0, 1, 1);
      arm_dut(1'b0);
      run(0, 1, 0, 0, 1'b0, -1, 0, -1, -1);
      cfg(0, 0, 255); cfg(0, 1, 2);
      arm_dut(1'b0);
      run(255, 2, 0, 0, 1'b0, -1, 0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
